// File: rtl/icache_tag_ctrl.sv
// Instruction cache tag controller: arbitrates flush, refill, invalidate and
// lookup onto a single-port read-first tag RAM and produces hit results.
module icache_tag_ctrl #(
    parameter bit FLUSH_ON_RESET = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lookup_valid_i,
    input  logic [31:0] lookup_addr_i,
    output logic        lookup_accept_o,
    output logic        hit_valid_o,
    output logic        hit_o,
    input  logic        refill_valid_i,
    input  logic [31:0] refill_addr_i,
    output logic        refill_accept_o,
    input  logic        inval_valid_i,
    input  logic [31:0] inval_addr_i,
    output logic        inval_accept_o,
    input  logic        flush_i,
    output logic        busy_o,
    output logic [7:0]  tag_addr_o,
    output logic [19:0] tag_data_o,
    output logic        tag_wr_o,
    input  logic [19:0] tag_data_i
);

    typedef enum logic {
        ST_FLUSH,
        ST_READY
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        pend_q;
    logic [18:0] ltag_q;
    logic        busy;
    logic        fl_win, rf_win, iv_win, lk_win;
    logic        unused;

    assign unused = ^{lookup_addr_i[4:0], refill_addr_i[4:0], inval_addr_i[31:13], inval_addr_i[4:0]};

    // Fixed priority: flush > refill > invalidate > lookup
    assign busy   = (state_q == ST_FLUSH);
    assign fl_win = ~busy & flush_i;
    assign rf_win = ~busy & ~flush_i & refill_valid_i;
    assign iv_win = ~busy & ~flush_i & ~refill_valid_i & inval_valid_i;
    assign lk_win = ~busy & ~flush_i & ~refill_valid_i & ~inval_valid_i & lookup_valid_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= FLUSH_ON_RESET ? ST_FLUSH : ST_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_FLUSH: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'hFF) state_d = ST_READY;
            end
            ST_READY: begin
                if (flush_i) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_comb begin
        tag_wr_o        = 1'b0;
        tag_addr_o      = '0;
        tag_data_o      = '0;
        refill_accept_o = 1'b0;
        inval_accept_o  = 1'b0;
        lookup_accept_o = 1'b0;
        unique case (1'b1)
            busy: begin
                tag_wr_o   = 1'b1;
                tag_addr_o = cnt_q;
            end
            rf_win: begin
                tag_wr_o        = 1'b1;
                tag_addr_o      = refill_addr_i[12:5];
                tag_data_o      = {1'b1, refill_addr_i[31:13]};
                refill_accept_o = 1'b1;
            end
            iv_win: begin
                tag_wr_o       = 1'b1;
                tag_addr_o     = inval_addr_i[12:5];
                inval_accept_o = 1'b1;
            end
            lk_win: begin
                tag_addr_o      = lookup_addr_i[12:5];
                lookup_accept_o = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pend_q <= 1'b0;
            ltag_q <= '0;
        end else begin
            pend_q <= lk_win;
            if (lk_win) ltag_q <= lookup_addr_i[31:13];
        end
    end

    // RAM output belongs to the lookup accepted last cycle
    assign busy_o      = busy;
    assign hit_valid_o = pend_q;
    assign hit_o       = pend_q & tag_data_i[19] & (tag_data_i[18:0] == ltag_q);

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Bench for icache_tag_ctrl: tag RAM model, vector table for READY traffic,
// hand sequences for flush, mid-flush reset and reset with a pending result.
module tb_icache_tag_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        lookup_valid_i, refill_valid_i, inval_valid_i, flush_i;
    logic [31:0] lookup_addr_i, refill_addr_i, inval_addr_i;
    logic        lookup_accept_o, refill_accept_o, inval_accept_o;
    logic        hit_valid_o, hit_o, busy_o, tag_wr_o;
    logic [7:0]  tag_addr_o;
    logic [19:0] tag_data_o, tag_data_i;

    logic [19:0] mem [256];
    int tests = 0;
    int fails = 0;
    logic sbq[$];

    typedef struct {
        logic        fl, rv;
        logic [31:0] ra;
        logic        iv;
        logic [31:0] ia;
        logic        lv;
        logic [31:0] la;
        logic        er, ei, el, eh;
    } vec_t;

    vec_t tbl[$];

    icache_tag_ctrl #(.FLUSH_ON_RESET(1'b1)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .lookup_valid_i(lookup_valid_i), .lookup_addr_i(lookup_addr_i),
        .lookup_accept_o(lookup_accept_o),
        .hit_valid_o(hit_valid_o), .hit_o(hit_o),
        .refill_valid_i(refill_valid_i), .refill_addr_i(refill_addr_i),
        .refill_accept_o(refill_accept_o),
        .inval_valid_i(inval_valid_i), .inval_addr_i(inval_addr_i),
        .inval_accept_o(inval_accept_o),
        .flush_i(flush_i), .busy_o(busy_o),
        .tag_addr_o(tag_addr_o), .tag_data_o(tag_data_o),
        .tag_wr_o(tag_wr_o), .tag_data_i(tag_data_i)
    );

    always #5 clk_i = ~clk_i;

    // Single-port read-first tag RAM with registered read
    always @(posedge clk_i) begin
        if (tag_wr_o) mem[tag_addr_o] <= tag_data_o;
        tag_data_i <= mem[tag_addr_o];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(logic fl, logic rv, logic [31:0] ra, logic iv,
                                logic [31:0] ia, logic lv, logic [31:0] la,
                                logic er, logic ei, logic el, logic eh);
        vec_t v;
        v.fl = fl; v.rv = rv; v.ra = ra; v.iv = iv; v.ia = ia;
        v.lv = lv; v.la = la; v.er = er; v.ei = ei; v.el = el; v.eh = eh;
        return v;
    endfunction

    task automatic check_hit();
        logic e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("hit_valid", 32'(hit_valid_o), 1);
            chk("hit", 32'(hit_o), 32'(e));
        end else begin
            chk("hit_valid_idle", 32'(hit_valid_o), 0);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic apply(input vec_t v);
        check_hit();
        flush_i = v.fl;
        refill_valid_i = v.rv; refill_addr_i = v.ra;
        inval_valid_i = v.iv;  inval_addr_i = v.ia;
        lookup_valid_i = v.lv; lookup_addr_i = v.la;
        #1;
        chk("busy_ready", 32'(busy_o), 0);
        chk("refill_acc", 32'(refill_accept_o), 32'(v.er));
        chk("inval_acc", 32'(inval_accept_o), 32'(v.ei));
        chk("lookup_acc", 32'(lookup_accept_o), 32'(v.el));
        if (v.er) begin
            chk("rf_wr", 32'(tag_wr_o), 1);
            chk("rf_addr", 32'(tag_addr_o), 32'(v.ra[12:5]));
            chk("rf_data", 32'(tag_data_o), 32'({1'b1, v.ra[31:13]}));
        end else if (v.ei) begin
            chk("iv_wr", 32'(tag_wr_o), 1);
            chk("iv_addr", 32'(tag_addr_o), 32'(v.ia[12:5]));
            chk("iv_data", 32'(tag_data_o), 0);
        end else if (v.el) begin
            chk("lk_wr", 32'(tag_wr_o), 0);
            chk("lk_addr", 32'(tag_addr_o), 32'(v.la[12:5]));
            sbq.push_back(v.eh);
        end else begin
            chk("idle_wr", 32'(tag_wr_o), 0);
        end
        next_cycle();
    endtask

    // Requests held high throughout: none may be accepted, flush must not restart
    task automatic flush_run(input int n, input int start);
        for (int i = 0; i < n; i++) begin
            check_hit();
            flush_i = 1'b1;
            refill_valid_i = 1'b1; refill_addr_i = 32'h0000_2040;
            inval_valid_i = 1'b1;  inval_addr_i = 32'h0000_2040;
            lookup_valid_i = 1'b1; lookup_addr_i = 32'h0000_2040;
            #1;
            chk("fl_busy", 32'(busy_o), 1);
            chk("fl_wr", 32'(tag_wr_o), 1);
            chk("fl_addr", 32'(tag_addr_o), 32'(start + i));
            chk("fl_data", 32'(tag_data_o), 0);
            chk("fl_acc", 32'({refill_accept_o, inval_accept_o, lookup_accept_o}), 0);
            next_cycle();
        end
    endtask

    initial begin
        rst_i = 1'b0;
        flush_i = 0; refill_valid_i = 0; inval_valid_i = 0; lookup_valid_i = 0;
        refill_addr_i = 0; inval_addr_i = 0; lookup_addr_i = 0;

        tbl.push_back(mk(0, 1, 32'h0000_2040, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0000_2040, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0000_4040, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 32'h0000_4060, 0, 0, 1, 32'h0000_4060, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0000_4060, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0000_2040, 1, 32'h0000_2040, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0000_2040, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'hFFFF_FFE0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'hFFFF_FFE0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0000_1FE0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0000_0020, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 32'h8000_2040, 1, 32'h0000_2040, 1, 32'h0000_2040, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h8000_2040, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0000_2040, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 32'h0000_2040, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0000_2040, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0000_4060, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 32'h0000_6000, 0, 0, 1, 32'h0000_4060, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0000_4060, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'hFFFF_FFE0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0000_2040, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 32'h0000_4060, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 32'h0000_0000, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0000_0000, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0000_0020, 0, 0, 1, 0));

        repeat (3) @(negedge clk_i);
        chk("rst_busy", 32'(busy_o), 1);
        chk("rst_hv", 32'(hit_valid_o), 0);
        chk("rst_hit", 32'(hit_o), 0);
        chk("rst_cnt", 32'(tag_addr_o), 0);
        rst_i = 1'b1;
        flush_run(256, 0);

        foreach (tbl[k]) begin
            apply(tbl[k]);
            if (tbl[k].fl) flush_run(256, 0);
        end

        // Reset in the middle of a flush
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        flush_run(100, 0);
        check_hit();
        rst_i = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy_o), 1);
        chk("midrst_cnt", 32'(tag_addr_o), 0);
        chk("midrst_hv", 32'(hit_valid_o), 0);
        repeat (2) next_cycle();
        rst_i = 1'b1;
        flush_run(256, 0);

        // Reset while a lookup result is due
        apply(mk(0, 0, 0, 0, 0, 1, 32'h0000_0000, 0, 0, 1, 0));
        rst_i = 1'b0;
        #1;
        chk("pendrst_hv", 32'(hit_valid_o), 0);
        chk("pendrst_hit", 32'(hit_o), 0);
        sbq.delete();
        repeat (2) next_cycle();
        rst_i = 1'b1;
        flush_run(256, 0);
        apply(mk(0, 0, 0, 0, 0, 1, 32'h0000_0000, 0, 0, 1, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
